ctrl_unit: RTL and testbench

- Multi-cycle fetch/decode/sequence controller; the driving end of the datapath control interface.
- Fetches 32-bit instruction words from instruction memory at the datapath PC and decodes them into datapath controls: alucode, op1, op2, imControl, flag, flag1, regenable, ramenable, pcControl, writecode.
- Paces the datapath: exactly one dp_step pulse per retired instruction; the datapath advances PC only on that pulse.

---
 rtl/ctrl_unit.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_ctrl_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_unit
//  Purpose  : Multi-cycle fetch / decode / sequence controller. Fetches 32-bit
//             instruction words at the datapath PC, decodes them into datapath
//             control fields and paces the datapath with one dp_step pulse per
//             retired instruction.
//  Ports    : clock, reset (async, active-high)
//             PC                         - current datapath PC
//             imem_addr/req/valid/data   - instruction fetch handshake
//             alucode, op1, op2, imControl, flag, flag1, ramenable,
//             pcControl, writecode       - decoded controls (DECODE..WB)
//             regenable, dp_step         - one-cycle WB strobes
//             halted, illegal            - sticky status flags
//             retired, stall_cycles      - perf counters (CTRL_PERF_EN only)
//  Options  : define CTRL_PERF_EN to add the retired / stall_cycles counters.
//  Revision : 1.0  initial release
// ============================================================================
module ctrl_unit #(
    parameter int ADDR_W  = 10,
    parameter int MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       PC,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_req,
    input  logic              imem_valid,
    input  logic [31:0]       imem_data,
    output logic [4:0]        alucode,
    output logic [2:0]        op1,
    output logic [20:0]       op2,
    output logic              imControl,
    output logic              flag,
    output logic              flag1,
    output logic              regenable,
    output logic [1:0]        ramenable,
    output logic [2:0]        pcControl,
    output logic [1:0]        writecode,
    output logic              dp_step,
    output logic              halted,
    output logic              illegal
`ifdef CTRL_PERF_EN
    ,
    output logic [31:0]       retired,
    output logic [31:0]       stall_cycles
`endif
);

    localparam logic [2:0] c_S_FETCH  = 3'd0;
    localparam logic [2:0] c_S_DECODE = 3'd1;
    localparam logic [2:0] c_S_EXEC   = 3'd2;
    localparam logic [2:0] c_S_MEMW   = 3'd3;
    localparam logic [2:0] c_S_WB     = 3'd4;
    localparam logic [2:0] c_S_HALT   = 3'd5;

    localparam logic [4:0] c_OP_MOV   = 5'd12;
    localparam logic [4:0] c_OP_STORE = 5'd20;
    localparam logic [4:0] c_OP_LOAD  = 5'd21;
    localparam logic [4:0] c_OP_HALT  = 5'd23;

    localparam bit         c_HAS_MEMW  = (MEM_LAT > 0);
    localparam logic [2:0] c_MEMW_LAST = 3'((MEM_LAT > 0) ? (MEM_LAT - 1) : 0);

    typedef struct packed {
        logic [4:0]  alucode;
        logic [2:0]  op1;
        logic [20:0] op2;
        logic        imm;
        logic        flag;
        logic        flag1;
        logic [1:0]  ram;
        logic [2:0]  pcc;
        logic [1:0]  wc;
    } ctrl_t;

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [31:0]       r_instr;
    logic [2:0]        r_memw_cnt;

    ctrl_t             r_ctrl;
    ctrl_t             w_ctrl;
    ctrl_t             w_dec;
    logic [4:0]        w_dec_op;

    logic [ADDR_W-1:0] r_imem_addr;
    logic [ADDR_W-1:0] w_imem_addr;
    logic              r_imem_req;
    logic              w_imem_req;
    logic              r_regenable;
    logic              w_regenable;
    logic              r_dp_step;
    logic              w_dp_step;
    logic              r_halted;
    logic              w_halted;
    logic              r_illegal;
    logic              w_illegal;

    logic [4:0]        w_cur_op;
    logic              w_accept;
    logic              w_mem_op;
    logic              w_writes;

    // Only opcode and RAM-operand bits of the held word steer sequencing.
    logic              w_unused_bits;
    assign w_unused_bits = ^{PC[31:ADDR_W], r_instr[26:23], r_instr[20:0]};

    assign w_cur_op = r_instr[31:27];
    assign w_accept = (r_state == c_S_FETCH) && r_imem_req && imem_valid;
    assign w_mem_op = r_instr[22] | r_instr[21] | (w_cur_op == c_OP_LOAD);
    assign w_writes = (w_cur_op <= c_OP_MOV) || (w_cur_op == c_OP_LOAD);

    // ------------------------------------------------------------------
    // Decode of the incoming instruction word (used at the accept edge)
    // ------------------------------------------------------------------
    assign w_dec_op = imem_data[31:27];

    always_comb begin
        w_dec       = '0;
        w_dec.op1   = imem_data[26:24];
        w_dec.imm   = imem_data[23];
        w_dec.flag  = imem_data[22];
        w_dec.flag1 = imem_data[21];
        w_dec.op2   = imem_data[20:0];
        if (w_dec_op <= 5'd11) begin
            w_dec.alucode = w_dec_op;
        end
        if ((w_dec_op == c_OP_MOV) || (w_dec_op == c_OP_LOAD)) begin
            w_dec.wc = 2'd1;
        end
        if ((w_dec_op >= 5'd13) && (w_dec_op <= 5'd19)) begin
            w_dec.pcc = 3'(w_dec_op - 5'd12);
        end
        if (w_dec_op == c_OP_STORE) begin
            w_dec.ram = 2'b01;
        end
        if (w_dec_op == c_OP_LOAD) begin
            w_dec.ram = 2'b10;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_FETCH:  if (w_accept) w_next_state = c_S_DECODE;
            c_S_DECODE: w_next_state = c_S_EXEC;
            c_S_EXEC:   w_next_state = (w_mem_op && c_HAS_MEMW) ? c_S_MEMW : c_S_WB;
            c_S_MEMW:   if (r_memw_cnt == c_MEMW_LAST) w_next_state = c_S_WB;
            c_S_WB:     w_next_state = (w_cur_op == c_OP_HALT) ? c_S_HALT : c_S_FETCH;
            c_S_HALT:   w_next_state = c_S_HALT;
            default:    w_next_state = c_S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: output logic. Computes the value every output takes
    // in the next cycle, so all outputs leave the block from flops.
    // ------------------------------------------------------------------
    always_comb begin
        w_imem_req  = r_imem_req;
        w_imem_addr = r_imem_addr;
        w_ctrl      = r_ctrl;
        w_regenable = 1'b0;
        w_dp_step   = 1'b0;
        w_halted    = r_halted;
        w_illegal   = r_illegal;
        case (r_state)
            c_S_FETCH: begin
                if (!r_imem_req) begin
                    // First cycle after reset: launch the request.
                    w_imem_req  = 1'b1;
                    w_imem_addr = PC[ADDR_W-1:0];
                end else if (imem_valid) begin
                    w_imem_req = 1'b0;
                    w_ctrl     = w_dec;
                    if (w_dec_op >= 5'd24) begin
                        w_illegal = 1'b1;
                    end
                end
            end
            c_S_EXEC, c_S_MEMW: begin
                if (w_next_state == c_S_WB) begin
                    w_dp_step   = 1'b1;
                    w_regenable = w_writes;
                end
            end
            c_S_WB: begin
                w_ctrl = '0;
                if (w_next_state == c_S_HALT) begin
                    w_halted = 1'b1;
                end else begin
                    // The datapath commits the new PC during the dp_step
                    // cycle, so the PC seen here is the next fetch address.
                    w_imem_req  = 1'b1;
                    w_imem_addr = PC[ADDR_W-1:0];
                end
            end
            default: ;
        endcase
    end

    // Output / instruction registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_imem_req  <= 1'b0;
            r_imem_addr <= '0;
            r_ctrl      <= '0;
            r_regenable <= 1'b0;
            r_dp_step   <= 1'b0;
            r_halted    <= 1'b0;
            r_illegal   <= 1'b0;
            r_instr     <= '0;
        end else begin
            r_imem_req  <= w_imem_req;
            r_imem_addr <= w_imem_addr;
            r_ctrl      <= w_ctrl;
            r_regenable <= w_regenable;
            r_dp_step   <= w_dp_step;
            r_halted    <= w_halted;
            r_illegal   <= w_illegal;
            if (w_accept) begin
                r_instr <= imem_data;
            end
        end
    end

    // Memory-wait counter; zero whenever MEMW is not active, so it is
    // already cleared on entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_memw_cnt <= '0;
        end else if (r_state == c_S_MEMW) begin
            r_memw_cnt <= r_memw_cnt + 3'd1;
        end else begin
            r_memw_cnt <= '0;
        end
    end

    assign imem_addr = r_imem_addr;
    assign imem_req  = r_imem_req;
    assign alucode   = r_ctrl.alucode;
    assign op1       = r_ctrl.op1;
    assign op2       = r_ctrl.op2;
    assign imControl = r_ctrl.imm;
    assign flag      = r_ctrl.flag;
    assign flag1     = r_ctrl.flag1;
    assign ramenable = r_ctrl.ram;
    assign pcControl = r_ctrl.pcc;
    assign writecode = r_ctrl.wc;
    assign regenable = r_regenable;
    assign dp_step   = r_dp_step;
    assign halted    = r_halted;
    assign illegal   = r_illegal;

`ifdef CTRL_PERF_EN
    logic [31:0] r_retired;
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_retired      <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (r_dp_step) begin
                r_retired <= r_retired + 32'd1;
            end
            if ((r_state == c_S_FETCH) && r_imem_req && !imem_valid) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign retired      = r_retired;
    assign stall_cycles = r_stall_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ctrl_unit
//  Purpose  : Self-checking bench for ctrl_unit. Drives directed and random
//             instruction streams, models the datapath PC, and compares every
//             cycle against expectations derived from the opcode map.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ctrl_unit;

    localparam int TB_ADDR_W  = 10;
    localparam int TB_MEM_LAT = 3;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [31:0]          PC;
    logic [TB_ADDR_W-1:0] imem_addr;
    logic                 imem_req;
    logic                 imem_valid;
    logic [31:0]          imem_data;
    logic [4:0]           alucode;
    logic [2:0]           op1;
    logic [20:0]          op2;
    logic                 imControl;
    logic                 flag;
    logic                 flag1;
    logic                 regenable;
    logic [1:0]           ramenable;
    logic [2:0]           pcControl;
    logic [1:0]           writecode;
    logic                 dp_step;
    logic                 halted;
    logic                 illegal;
`ifdef CTRL_PERF_EN
    logic [31:0]          retired;
    logic [31:0]          stall_cycles;
`endif

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_pc;
    logic        exp_illegal;
    logic [31:0] exp_retired;
    logic [31:0] exp_stall;

    ctrl_unit #(
        .ADDR_W (TB_ADDR_W),
        .MEM_LAT(TB_MEM_LAT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .PC          (PC),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_valid  (imem_valid),
        .imem_data   (imem_data),
        .alucode     (alucode),
        .op1         (op1),
        .op2         (op2),
        .imControl   (imControl),
        .flag        (flag),
        .flag1       (flag1),
        .regenable   (regenable),
        .ramenable   (ramenable),
        .pcControl   (pcControl),
        .writecode   (writecode),
        .dp_step     (dp_step),
        .halted      (halted),
        .illegal     (illegal)
`ifdef CTRL_PERF_EN
        ,
        .retired     (retired),
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    wire [38:0] w_ctrl_obs = {alucode, op1, op2, imControl, flag, flag1,
                              ramenable, pcControl, writecode};
    wire [53:0] w_all_obs  = {imem_addr, imem_req, w_ctrl_obs, regenable,
                              dp_step, halted, illegal};

    // Runs one instruction from its first request cycle through WB.
    // The bench plays the datapath: PC is committed during the dp_step cycle
    // (taken branch: PC + op2, otherwise PC + 1).
    task automatic run_instr(input logic [31:0] word, input int waits);
        logic [4:0]  op;
        logic [4:0]  e_alu;
        logic [2:0]  e_pcc;
        logic [1:0]  e_ram;
        logic [1:0]  e_wc;
        logic        e_reg;
        logic        e_ill;
        logic [38:0] e_ctrl;
        int          last;
        op     = word[31:27];
        e_alu  = (op <= 5'd11) ? op : 5'd0;
        e_pcc  = (op >= 5'd13 && op <= 5'd19) ? 3'(op - 5'd12) : 3'd0;
        e_ram  = (op == 5'd20) ? 2'b01 : (op == 5'd21) ? 2'b10 : 2'b00;
        e_wc   = (op == 5'd12 || op == 5'd21) ? 2'd1 : 2'd0;
        e_reg  = (op <= 5'd12) || (op == 5'd21);
        e_ill  = exp_illegal | (op >= 5'd24);
        e_ctrl = {e_alu, word[26:24], word[20:0], word[23], word[22], word[21],
                  e_ram, e_pcc, e_wc};
        last   = 3 + ((word[22] || word[21] || op == 5'd21) ? TB_MEM_LAT : 0);

        for (int k = 0; k <= waits; k++) begin
            @(negedge clock);
            n_checks++;
            if (imem_req !== 1'b1)
                $display("FAIL fetch_req: got %b expected 1 (op %0d cyc %0d)", imem_req, op, k);
            else n_pass++;
            n_checks++;
            if (imem_addr !== exp_pc[TB_ADDR_W-1:0])
                $display("FAIL fetch_addr: got %0h expected %0h", imem_addr, exp_pc[TB_ADDR_W-1:0]);
            else n_pass++;
            n_checks++;
            if ({w_ctrl_obs, regenable, dp_step, halted, illegal} !== {39'd0, 3'b000, exp_illegal})
                $display("FAIL fetch_idle: got ctrl %0h strobes %b%b%b%b expected 0 / illegal %b",
                         w_ctrl_obs, regenable, dp_step, halted, illegal, exp_illegal);
            else n_pass++;
`ifdef CTRL_PERF_EN
            if (k == 0) begin
                n_checks++;
                if (retired !== exp_retired)
                    $display("FAIL perf_retired: got %0d expected %0d", retired, exp_retired);
                else n_pass++;
                n_checks++;
                if (stall_cycles !== exp_stall)
                    $display("FAIL perf_stall: got %0d expected %0d", stall_cycles, exp_stall);
                else n_pass++;
            end
`endif
            imem_valid = (k == waits);
            imem_data  = (k == waits) ? word : $urandom;
            if (k < waits) exp_stall++;
        end

        for (int c = 1; c <= last; c++) begin
            @(negedge clock);
            imem_valid = 1'b0;
            imem_data  = $urandom;
            n_checks++;
            if (w_ctrl_obs !== e_ctrl)
                $display("FAIL ctrl_fields: got %0h expected %0h (op %0d cyc %0d)", w_ctrl_obs, e_ctrl, op, c);
            else n_pass++;
            n_checks++;
            if ({imem_req, dp_step, regenable, halted, illegal} !==
                {1'b0, (c == last), (c == last) && e_reg, 1'b0, e_ill})
                $display("FAIL strobes: got req/step/reg/halt/ill %b%b%b%b%b expected %b%b%b0%b (op %0d cyc %0d)",
                         imem_req, dp_step, regenable, halted, illegal,
                         1'b0, (c == last), (c == last) && e_reg, e_ill, op, c);
            else n_pass++;
            if (c == last) begin
                exp_pc = (e_pcc != 3'd0) ? exp_pc + {11'd0, word[20:0]} : exp_pc + 32'd1;
                PC     = exp_pc;
                exp_retired++;
            end
        end
        exp_illegal = e_ill;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        imem_valid  = 1'b0;
        imem_data   = '0;
        PC          = 32'd0;
        exp_pc      = 32'd0;
        exp_illegal = 1'b0;
        exp_retired = 32'd0;
        exp_stall   = 32'd0;
        repeat (2) @(negedge clock);
        n_checks++;
        if (w_all_obs !== 54'd0)
            $display("FAIL reset_outputs: got %0h expected 0", w_all_obs);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_alu_add();
        run_instr({5'd1, 3'd0, 1'b1, 1'b0, 1'b0, 21'd5}, 0);
    endtask

    task automatic test_branch();
        run_instr(32'h68000003, 0);
        run_instr({5'd0, 3'd4, 1'b0, 1'b0, 1'b0, 21'd9}, 0);
    endtask

    task automatic test_load_memw();
        run_instr({5'd21, 3'd3, 1'b0, 1'b0, 1'b0, 21'd40}, 0);
        run_instr({5'd20, 3'd1, 1'b1, 1'b0, 1'b0, 21'd7}, 1);
    endtask

    task automatic test_fetch_stall();
        run_instr(32'hB0000000, 5);
    endtask

    task automatic test_illegal();
        run_instr(32'hF8000000, 0);
        run_instr({5'd12, 3'd2, 1'b1, 1'b0, 1'b0, 21'd3}, 2);
    endtask

    task automatic test_reset_in_memw();
        @(negedge clock);
        n_checks++;
        if (imem_req !== 1'b1)
            $display("FAIL rst_mid_req: got %b expected 1", imem_req);
        else n_pass++;
        imem_valid = 1'b1;
        imem_data  = {5'd21, 3'd5, 1'b0, 1'b0, 1'b0, 21'd2};
        repeat (4) begin
            @(negedge clock);
            imem_valid = 1'b0;
        end
        // Now in the second MEMW cycle of the load.
        n_checks++;
        if ({ramenable, dp_step, regenable} !== 4'b1000)
            $display("FAIL rst_mid_memw: got ram/step/reg %b%b%b expected 1000", ramenable, dp_step, regenable);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++;
        if (w_all_obs !== 54'd0)
            $display("FAIL reset_async: got %0h expected 0", w_all_obs);
        else n_pass++;
        PC          = 32'd100;
        exp_pc      = 32'd100;
        exp_illegal = 1'b0;
        exp_retired = 32'd0;
        exp_stall   = 32'd0;
        @(negedge clock);
        n_checks++;
        if (w_all_obs !== 54'd0)
            $display("FAIL reset_hold: got %0h expected 0", w_all_obs);
        else n_pass++;
        reset = 1'b0;
        run_instr(32'hB0000000, 1);
    endtask

    task automatic test_random();
        logic [31:0] rnd;
        logic [4:0]  op;
        for (int i = 0; i < 40; i++) begin
            rnd = $urandom;
            op  = 5'($urandom_range(0, 31));
            if (op == 5'd23) op = 5'd22;
            run_instr({op, rnd[26:0]}, int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_halt();
        run_instr(32'hB8000000, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            imem_valid = 1'b1;
            n_checks++;
            if ({imem_req, halted, dp_step, regenable} !== 4'b0100)
                $display("FAIL halt_hold: got req/halt/step/reg %b%b%b%b expected 0100 (cyc %0d)",
                         imem_req, halted, dp_step, regenable, i);
            else n_pass++;
        end
        imem_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu_add();
        test_branch();
        test_load_memw();
        test_fetch_stall();
        test_illegal();
        test_reset_in_memw();
        test_random();
        test_halt();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
